field_scan_sequencer: RTL and testbench
=======================================

# field_scan_sequencer

Sequences the 3-bit field extractor. It accepts one packed 16-bit word over a valid/ready handshake, then emits the word's enabled 3-bit fields one per handshake. Emission starts at the field index carried in the word's selector bits and wraps around. The block sits between a word producer and a narrow 3-bit consumer, and replaces a single-shot selector lookup with a full, back-pressurable scan.

## Interface
- FIELD_W, 3, width of one field
- N_FIELDS, 4, fields per word; index width is log2(N_FIELDS) = 2
- DATA_W, 16, input word width; layout: [1:0] start index, field k at [2+3k +: 3], [15:14] ignored
---
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_data  in  16  packed word
- i_valid  in  1  i_data/i_mask valid
- o_ready  out  1  block can accept a word (registered)
- i_mask  in  4  field enable, bit k enables field k; sampled with the word
- o_data  out  3  current field value
- o_idx  out  2  index of current field
- o_valid  out  1  o_data/o_idx valid
- o_last  out  1  current field is the final one of this word
- i_ready  in  1  consumer accepts the field
- o_busy  out  1  scan in progress (state == EMIT)

## Operation
- States: IDLE and EMIT.
- Reset (i_rst_n = 0 at an edge): state IDLE; o_ready, o_valid, o_last and o_busy are 0; o_data and o_idx are 0; word and remaining-mask registers are cleared. This takes priority over everything else, including mid-scan; a partial scan is abandoned with no further beats.
- IDLE: o_ready becomes 1 on the first edge after reset release.
- Accept: an edge with i_valid && o_ready.
  - The word is captured and rem_mask = i_mask.
  - If i_mask == 0: the word is discarded, the block stays in IDLE, o_ready stays 1 and no beat is emitted.
  - Otherwise: o_ready goes to 0 and the state goes to EMIT. o_idx is set to the first set bit of rem_mask, searching from start index s = i_data[1:0] upward and wrapping 3→0. o_data is set to field[o_idx] and o_valid to 1.
- EMIT beat handshake: an edge with o_valid && i_ready.
  - The rem_mask bit for o_idx is cleared.
  - If bits remain, o_idx advances to the next set bit after o_idx (wrapping) and o_data is updated.
  - If none remain (o_last was 1), the state returns to IDLE, o_valid and o_last go to 0, and o_ready goes to 1.
- o_last = 1 exactly when rem_mask has only the o_idx bit set.
- Stall: while o_valid && !i_ready, o_data, o_idx and o_last hold stable. i_data changes are ignored because the word is already captured.
- No overlap: a new word is never accepted during EMIT.

## Timing
- Accept edge k gives the first beat valid after edge k (one-cycle latency). All outputs are registered.
- Throughput with i_ready held high: popcount(mask) beats, followed by one IDLE cycle before the next accept.
- The last-beat handshake at edge m gives o_ready = 1 after edge m. The earliest next accept is edge m+1.
- Simultaneous i_valid during EMIT has no effect.

## Configuration
- FIELD_SEQ_PARITY_EN defined: adds the port o_parity (out, 1) = XOR of o_data bits, registered with o_data and reset to 0.
- FIELD_SEQ_PARITY_EN undefined: the port is absent and no parity logic is built. All other behaviour is identical.

## Structure
- Package field_seq_pkg holds:
  - FIELD_W, N_FIELDS and IDX_W = 2
  - the state enum {IDLE, EMIT}
  - a field-offset function (2 + 3k)
- Sub-module field_seq_pick: combinational rotating priority finder. Inputs are a 4-bit mask and a 2-bit start index. Outputs are found, the index, and a last flag. It is used for both the first pick and the advance (start = o_idx+1).

## Test plan
- i_data=16'h2346 (s=2, fields 1,2,3,4), i_mask=4'hF, i_ready=1 → beats idx/data 2/3, 3/4, 0/1, 1/2; o_last only on idx 1; o_ready=1 after the 4th beat.
- Same word, i_mask=4'b1010 → beats 3/4 then 1/2 with o_last; exactly 2 beats.
- i_mask=4'hF, i_ready low for 3 cycles after the first beat → idx 2/data 3 held for 4 cycles, then the sequence continues unchanged.
- i_mask=4'h0 with i_valid=1 → no o_valid; o_ready stays 1; a following word with mask 4'h1 is accepted on the next edge and emits idx 0/data 1 with o_last=1.
- Reset (i_rst_n=0) during the 2nd beat → after that edge o_valid, o_last, o_busy, o_data and o_idx are 0; o_ready is 0, then 1 one edge after release.
- FIELD_SEQ_PARITY_EN defined, scan of 16'h2346 with mask 4'hF → o_parity 0,1,1,1 for data 3,4,1,2.

Source files
------------

// File: rtl/field_seq_pkg.sv
// Shared types and constants for the field scan sequencer.
package field_seq_pkg;

    localparam int unsigned FIELD_W  = 3;
    localparam int unsigned N_FIELDS = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned DATA_W   = 16;

    typedef enum logic [0:0] {IDLE, EMIT} state_e;

    // Bit offset of field k inside the packed word; the low two bits hold the start index.
    function automatic logic [3:0] field_offset(input logic [IDX_W-1:0] k);
        return 4'd2 + 4'd3 * {2'b00, k};
    endfunction

endpackage

// File: rtl/field_seq_pick.sv
// Rotating priority finder: first set mask bit at or after start, wrapping.
module field_seq_pick
    import field_seq_pkg::*;
(
    input  logic [N_FIELDS-1:0] mask,
    input  logic [IDX_W-1:0]    start,
    output logic                found,
    output logic [IDX_W-1:0]    idx,
    output logic                last
);

    logic [IDX_W-1:0]    cand;
    logic [N_FIELDS-1:0] others;

    // Walk from the farthest candidate back to start so the nearest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int i = N_FIELDS - 1; i >= 0; i--) begin
            cand = IDX_W'(start + IDX_W'(i));
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    assign others = mask & ~(N_FIELDS'(1) << idx);
    assign last   = found && (others == '0);

endmodule

// File: rtl/field_scan_sequencer.sv
// Accepts a packed word and emits its enabled 3-bit fields one per handshake.
// Optional o_parity port is built when FIELD_SEQ_PARITY_EN is defined.
module field_scan_sequencer
    import field_seq_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [N_FIELDS-1:0] i_mask,
    output logic [FIELD_W-1:0]  o_data,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_valid,
    output logic                o_last,
    input  logic                i_ready,
`ifdef FIELD_SEQ_PARITY_EN
    output logic                o_parity,
`endif
    output logic                o_busy
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [N_FIELDS-1:0] rem_q, rem_d, rem_clr;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [FIELD_W-1:0]  data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                ready_q, ready_d;

    logic [N_FIELDS-1:0] pick_mask;
    logic [IDX_W-1:0]    pick_start, pick_idx;
    logic                pick_found, pick_last;
    logic [DATA_W-1:0]   word_sel;
    logic [FIELD_W-1:0]  pick_data;
    logic                accept, beat_done;

    assign accept    = i_valid && ready_q;
    assign beat_done = valid_q && i_ready;
    assign rem_clr   = rem_q & ~(N_FIELDS'(1) << idx_q);

    // One finder serves both the first pick (from the incoming word) and each advance.
    always_comb begin
        if (state_q == IDLE) begin
            pick_mask  = i_mask;
            pick_start = i_data[IDX_W-1:0];
            word_sel   = i_data;
        end else begin
            pick_mask  = rem_clr;
            pick_start = idx_q + 2'd1;
            word_sel   = word_q;
        end
    end

    field_seq_pick u_pick (
        .mask  (pick_mask),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx),
        .last  (pick_last)
    );

    assign pick_data = word_sel[field_offset(pick_idx) +: FIELD_W];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && pick_found) state_d = EMIT;
            EMIT:    if (beat_done && !pick_found) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_d  = word_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    word_d = i_data;
                    rem_d  = i_mask;
                    if (pick_found) begin
                        ready_d = 1'b0;
                        valid_d = 1'b1;
                        idx_d   = pick_idx;
                        data_d  = pick_data;
                        last_d  = pick_last;
                    end
                end
            end
            EMIT: begin
                if (beat_done) begin
                    rem_d = rem_clr;
                    if (pick_found) begin
                        idx_d  = pick_idx;
                        data_d = pick_data;
                        last_d = pick_last;
                    end else begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            word_q  <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ready_q <= ready_d;
        end
    end

`ifdef FIELD_SEQ_PARITY_EN
    logic parity_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_d;
        end
    end

    assign o_parity = parity_q;
`endif

    assign o_ready = ready_q;
    assign o_data  = data_q;
    assign o_idx   = idx_q;
    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_busy  = (state_q == EMIT);

endmodule

// File: tb/tb_field_scan_sequencer.sv
// Directed self-checking bench for field_scan_sequencer.
module tb_field_scan_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [15:0] i_data;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_mask;
    logic [2:0]  o_data;
    logic [1:0]  o_idx;
    logic        o_valid;
    logic        o_last;
    logic        i_ready;
    logic        o_busy;
`ifdef FIELD_SEQ_PARITY_EN
    logic        o_parity;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 i_clk = ~i_clk;

    field_scan_sequencer dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_mask   (i_mask),
        .o_data   (o_data),
        .o_idx    (o_idx),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .i_ready  (i_ready),
`ifdef FIELD_SEQ_PARITY_EN
        .o_parity (o_parity),
`endif
        .o_busy   (o_busy)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    // Check the beat currently presented, then let the handshake edge pass.
    task automatic beat(input string tag, input int unsigned idx, input int unsigned data,
                        input int unsigned last);
        logic [2:0] d;
        d = 3'(data);
        check({tag, " valid"}, o_valid, 1);
        check({tag, " idx"}, o_idx, idx);
        check({tag, " data"}, o_data, data);
        check({tag, " last"}, o_last, last);
        check({tag, " busy"}, o_busy, 1);
        check({tag, " ready"}, o_ready, 0);
`ifdef FIELD_SEQ_PARITY_EN
        check({tag, " parity"}, o_parity, {31'd0, ^d});
`endif
        step();
    endtask

    task automatic idle_check(input string tag);
        check({tag, " valid"}, o_valid, 0);
        check({tag, " ready"}, o_ready, 1);
        check({tag, " busy"}, o_busy, 0);
    endtask

    task automatic send(input logic [15:0] data, input logic [3:0] mask);
        i_data  = data;
        i_mask  = mask;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_data  = '0;
        i_valid = 1'b0;
        i_mask  = '0;
        i_ready = 1'b1;
        step();
        step();
        check("rst valid", o_valid, 0);
        check("rst ready", o_ready, 0);
        check("rst busy", o_busy, 0);
        check("rst last", o_last, 0);
        check("rst data", o_data, 0);
        check("rst idx", o_idx, 0);
        i_rst_n = 1'b1;
        step();
        idle_check("post-rst");

        // Full scan starting at index 2
        send(16'h2346, 4'hF);
        beat("full b0", 2, 3, 0);
        beat("full b1", 3, 4, 0);
        beat("full b2", 0, 1, 0);
        beat("full b3", 1, 2, 1);
        idle_check("full end");

        // Sparse mask, i_valid held high during the scan must be ignored
        i_data  = 16'h2346;
        i_mask  = 4'b1010;
        i_valid = 1'b1;
        step();
        i_mask  = 4'hF;
        beat("sparse b0", 3, 4, 0);
        beat("sparse b1", 1, 2, 1);
        idle_check("sparse end");
        i_valid = 1'b0;

        // Stall: first beat held for 4 cycles, input word changes ignored
        i_ready = 1'b0;
        send(16'h2346, 4'hF);
        i_data = 16'hFFFF;
        beat("stall c0", 2, 3, 0);
        beat("stall c1", 2, 3, 0);
        beat("stall c2", 2, 3, 0);
        i_ready = 1'b1;
        beat("stall c3", 2, 3, 0);
        beat("stall b1", 3, 4, 0);
        beat("stall b2", 0, 1, 0);
        beat("stall b3", 1, 2, 1);
        idle_check("stall end");

        // Empty mask is discarded; next word accepted right after
        send(16'h2346, 4'h0);
        idle_check("empty");
        send(16'h2346, 4'h1);
        beat("single", 0, 1, 1);
        idle_check("single end");

        // Reset in the middle of a scan
        send(16'h2346, 4'hF);
        beat("rstmid b0", 2, 3, 0);
        check("rstmid b1 idx", o_idx, 3);
        i_rst_n = 1'b0;
        step();
        check("rstmid valid", o_valid, 0);
        check("rstmid last", o_last, 0);
        check("rstmid busy", o_busy, 0);
        check("rstmid data", o_data, 0);
        check("rstmid idx", o_idx, 0);
        check("rstmid ready", o_ready, 0);
        i_rst_n = 1'b1;
        step();
        idle_check("rstmid release");
        step();
        idle_check("rstmid quiet");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
